// File: rtl/poci_pkg.sv
// poci_pkg: shared types and widths for the SPI POCI transmitter.
//   poci_state_t : transaction phase (address byte, then data bytes)
//   poci_dbg_t   : snapshot of the posedge-side state registers for observation
package poci_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } poci_state_t;

    typedef struct packed {
        poci_state_t       state;
        logic [2:0]        bit_cnt;
        logic [BYTE_W-1:0] addr_sr;
    } poci_dbg_t;

endpackage

// File: rtl/poci_tx_if.sv
// poci_tx_if: signals between the POCI transmitter and the SPI top level.
//   serial_in  : PICO line, read only during the address byte
//   rd_data    : register value for rd_addr, from the combinational read mux
//   rd_addr    : read-mux select / current read address
//   serial_out : POCI pad bit
//   tx_active  : high while in the data phase
//   byte_done  : one-sclk pulse after each transmitted byte
// slave  = transmitter side, master = SPI top level / read mux side.
// There is no flow control: the transmitter advances every sclk edge and the
// read mux must settle rd_data within half an sclk period of rd_addr moving.
interface poci_tx_if;
    import poci_pkg::*;

    logic              serial_in;
    logic [BYTE_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              serial_out;
    logic              tx_active;
    logic              byte_done;

    modport slave (
        input  serial_in,
        input  rd_data,
        output rd_addr,
        output serial_out,
        output tx_active,
        output byte_done
    );

    modport master (
        output serial_in,
        output rd_data,
        input  rd_addr,
        input  serial_out,
        input  tx_active,
        input  byte_done
    );

endinterface

// File: rtl/poci_piso.sv
// poci_piso: negedge parallel-in / serial-out shifter driving the POCI pad.
//   sclk, rstn : SPI clock (mode 0) and async active-low reset
//   load       : snapshot din and launch its MSB on this negedge
//   shift      : launch the next bit of the held byte
//   din        : byte to transmit
//   serial_out : POCI bit; IDLE_OUT when neither load nor shift
module poci_piso
    import poci_pkg::*;
#(
    parameter logic IDLE_OUT = 1'b0
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] din,
    output logic              serial_out
);

    logic [BYTE_W-1:0] tx_sr;

    // The byte is captured into tx_sr at load, so later rd_data changes
    // cannot disturb the byte already on the wire.
    always_ff @(negedge sclk or negedge rstn) begin
        if (!rstn) begin
            tx_sr      <= '0;
            serial_out <= IDLE_OUT;
        end else if (load) begin
            serial_out <= din[BYTE_W-1];
            tx_sr      <= {din[BYTE_W-2:0], 1'b0};
        end else if (shift) begin
            serial_out <= tx_sr[BYTE_W-1];
            tx_sr      <= {tx_sr[BYTE_W-2:0], 1'b0};
        end else begin
            serial_out <= IDLE_OUT;
        end
    end

endmodule

// File: rtl/poci_tx.sv
// poci_tx: SPI POCI-side transmitter.
// Captures an address byte from serial_in, then streams register contents
// MSB-first on serial_out, one byte per 8 sclk cycles, auto-incrementing
// rd_addr after each byte. Only rstn leaves the data phase.
//   sclk, rstn : SPI clock (mode 0), async active-low reset
//   bus        : poci_tx_if.slave (serial_in, rd_data, rd_addr, serial_out,
//                tx_active, byte_done)
//   dbg        : state, bit_cnt and addr_sr for observation
module poci_tx
    import poci_pkg::*;
#(
    parameter logic IDLE_OUT = 1'b0
) (
    input  logic       sclk,
    input  logic       rstn,
    poci_tx_if.slave   bus,
    output poci_dbg_t  dbg
);

    poci_state_t       state;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] addr_sr;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              byte_done_q;
    logic              load;
    logic              shift;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_ADDR;
            bit_cnt     <= 3'd0;
            addr_sr     <= '0;
            rd_addr_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt + 3'd1;
            byte_done_q <= 1'b0;
            case (state)
                ST_ADDR: begin
                    addr_sr <= {addr_sr[BYTE_W-2:0], bus.serial_in};
                    if (bit_cnt == 3'd7) begin
                        rd_addr_q <= {addr_sr[BYTE_W-2:0], bus.serial_in};
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // serial_in is ignored here; writes are the receiver's job.
                    if (bit_cnt == 3'd7) begin
                        rd_addr_q   <= rd_addr_q + 8'd1;
                        byte_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // bit_cnt has already wrapped to 0 by the negedge after each byte
    // boundary, which is where the next byte is loaded.
    assign load  = (state == ST_DATA) && (bit_cnt == 3'd0);
    assign shift = (state == ST_DATA) && (bit_cnt != 3'd0);

    poci_piso #(
        .IDLE_OUT (IDLE_OUT)
    ) u_piso (
        .sclk       (sclk),
        .rstn       (rstn),
        .load       (load),
        .shift      (shift),
        .din        (bus.rd_data),
        .serial_out (bus.serial_out)
    );

    assign bus.rd_addr   = rd_addr_q;
    assign bus.tx_active = (state == ST_DATA);
    assign bus.byte_done = byte_done_q;

    assign dbg.state   = state;
    assign dbg.bit_cnt = bit_cnt;
    assign dbg.addr_sr = addr_sr;

endmodule

// File: doc/poci_tx.md
# poci_tx

SPI POCI-side transmitter: the controller-out counterpart to the PICO byte receiver.
- Captures the address byte at the start of each transaction, then returns register contents MSB-first on `serial_out`, one byte per 8 `sclk` cycles.
- Auto-increments the read address after every byte.
- Sits beside the PICO receiver at SPI top level; drives the read-mux select and the chip's POCI pad.

## Interface
- `IDLE_OUT`, default 1'b0: `serial_out` level outside data phase.
- `sclk` input 1: SPI clock, mode 0.
- `rstn` input 1: reset, asynchronous, active-low. Top level drives external reset ANDed with the idle-detect reset.
- `serial_in` input 1: PICO line; used only during the address byte.
- `rd_data` input 8: register value selected by `rd_addr`, from the combinational read mux.
- `rd_addr` output 8: read-mux select / current read address.
- `serial_out` output 1: POCI bit.
- `tx_active` output 1: high while in data phase.
- `byte_done` output 1: one-`sclk`-cycle pulse after each transmitted byte.

## Operation
- States: `ST_ADDR`, `ST_DATA`.
- `bit_cnt` (3 bit) increments on every posedge `sclk`, wrapping 7→0.
- **`ST_ADDR`**, on each posedge:
  - `addr_sr <= {addr_sr[6:0], serial_in}`.
  - When `bit_cnt==7`: `rd_addr <= {addr_sr[6:0], serial_in}`, go to `ST_DATA`.
- **`ST_DATA`**, on posedge with `bit_cnt==7`:
  - `rd_addr <= rd_addr + 1`, modulo 256 (0xFF→0x00).
  - `byte_done` high for the following cycle.
- No exit from `ST_DATA` except `rstn`. The transaction ends by idle-detect reset.
- **Negedge shift process (`tx_sr`, 8 bit):**
  - `ST_DATA` and `bit_cnt==0`: load, `serial_out <= rd_data[7]`, `tx_sr <= {rd_data[6:0],1'b0}`.
  - `ST_DATA` otherwise: `serial_out <= tx_sr[7]`, `tx_sr <= tx_sr << 1`.
  - `ST_ADDR`: `serial_out <= IDLE_OUT`.
- `tx_active` = (state == `ST_DATA`), taken from the state register. No combinational path from inputs.
- `serial_in` is ignored in `ST_DATA`. Simultaneous writes are handled by the receiver and do not affect `rd_addr`.

## Timing
- **Reset values** (asynchronous, immediate on `rstn` low, including mid-byte):
  - `state=ST_ADDR`, `bit_cnt=0`, `addr_sr=0`, `rd_addr=0x00`, `tx_sr=0`.
  - `serial_out=IDLE_OUT`, `tx_active=0`, `byte_done=0`.
- After `rstn` rises, the first posedge `sclk` is address bit 7.
- Address latency: `rd_addr` is valid after the 8th posedge.
- `rd_data` must settle within half an `sclk` period of any `rd_addr` change.
- The first data bit is launched on the negedge following the 8th posedge, so it is valid at posedge 9. Data bit k of byte n is sampled at posedge 8n+k+1.
- Each byte's data is snapshotted at its first negedge. Later `rd_data` changes do not corrupt the byte in flight.
- `byte_done` is asserted on posedge 8n+8 (n≥1) and cleared on the next posedge.
- A partial byte followed by reset is discarded. No state survives reset.

## Structure
- Package `poci_pkg`:
  - `typedef enum logic {ST_ADDR, ST_DATA} poci_state_t`.
  - `localparam BYTE_W = 8`, `ADDR_W = 8`.
- Sub-module `poci_piso`: the negedge parallel-in/serial-out shifter.
  - Inputs: `load`, `shift`, `din[7:0]`, `IDLE_OUT`.
  - Output: `serial_out`.
- The top holds the posedge FSM, `bit_cnt`, `addr_sr` and `rd_addr`.

## Test plan
- **Reset:** hold `rstn`=0 while toggling `sclk` → `serial_out`=0, `rd_addr`=0x00, `tx_active`=0, `byte_done`=0.
- **Single read:** mux model `rd_data` = 0xA0|`rd_addr`; shift address 0x05 → after posedge 8 `rd_addr`=0x05, `tx_active`=1; posedges 9–16 sample 1,0,1,0,0,1,0,1 (0xA5).
- **Burst:** address 0x10, 24 more clocks →
  - serialised bytes 0xB0, 0xB1, 0xB2 (model 0xA0+`rd_addr`);
  - `rd_addr` 0x11, 0x12, 0x13 after each byte;
  - exactly 3 `byte_done` pulses.
- **Wrap:** address 0xFF, two data bytes → reads of address 0xFF then 0x00; `rd_addr` ends 0x01.
- **Reset mid-byte:** assert `rstn` after 3 data bits → all outputs at reset values immediately. A new transaction at address 0x22 returns the 0x22 byte from bit 7.
- **Stability:** random `serial_in` during data phase and `rd_data` changing mid-byte → `rd_addr` sequence and in-flight byte unchanged.
